// File: rtl/rx_block_checker.sv
// Hardware checker for incrementing-counter block traffic arriving from rx_streamer.
// Verifies word sequence, first/last framing and block length, with saturating statistics.
module rx_block_checker #(
  parameter int g_data_width     = 64,
  parameter int g_block_size_min = 1,
  parameter int g_block_size_max = 3,
  parameter int g_cnt_width      = 32
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    clr_i,
  input  logic [g_data_width-1:0] rx_data_i,
  input  logic                    rx_valid_i,
  input  logic                    rx_first_p1_i,
  input  logic                    rx_last_p1_i,
  input  logic                    rx_lost_p1_i,
  output logic                    rx_dreq_o,
  output logic                    synced_o,
  output logic [g_cnt_width-1:0]  blocks_ok_o,
  output logic [g_cnt_width-1:0]  err_data_o,
  output logic [g_cnt_width-1:0]  err_frame_o,
  output logic [g_cnt_width-1:0]  err_size_o,
  output logic [g_cnt_width-1:0]  lost_o,
  output logic [2:0]              err_flags_p1_o
);

  // Length only needs to reach max+1 to flag an oversize block.
  localparam int c_len_width = $clog2(g_block_size_max + 2);

  localparam logic [c_len_width-1:0]  c_len_one  = c_len_width'(1);
  localparam logic [c_len_width-1:0]  c_len_min  = c_len_width'(g_block_size_min);
  localparam logic [c_len_width-1:0]  c_len_max  = c_len_width'(g_block_size_max);
  localparam logic [c_len_width-1:0]  c_len_sat  = c_len_width'(g_block_size_max + 1);
  localparam logic [g_data_width-1:0] c_data_one = g_data_width'(1);
  localparam logic [g_cnt_width-1:0]  c_cnt_one  = g_cnt_width'(1);

  localparam logic [0:0] st_idle     = 1'b0;
  localparam logic [0:0] st_in_block = 1'b1;

  logic [0:0]              state_r;
  logic [g_data_width-1:0] exp_r;
  logic [c_len_width-1:0]  len_r;
  logic                    blk_err_r;

  logic                    word;
  logic                    data_err;
  logic                    frame_err;
  logic                    in_blk;
  logic                    close;
  logic                    size_err;
  logic                    block_ok;
  logic [c_len_width-1:0]  len_nxt;
  logic                    blk_err_nxt;

  function automatic logic [g_cnt_width-1:0] sat_inc(input logic [g_cnt_width-1:0] cnt,
                                                     input logic inc);
    sat_inc = (inc && (cnt != '1)) ? cnt + c_cnt_one : cnt;
  endfunction

  // A lost pulse discards any record presented in the same cycle.
  always_comb begin
    word        = rx_valid_i & ~rx_lost_p1_i;
    data_err    = word & synced_o & (rx_data_i != exp_r);
    frame_err   = word & ((state_r == st_idle) ? ~rx_first_p1_i : rx_first_p1_i);
    in_blk      = word & (rx_first_p1_i | (state_r == st_in_block));
    len_nxt     = len_r;
    blk_err_nxt = blk_err_r;
    if (word && rx_first_p1_i) begin
      len_nxt     = c_len_one;
      blk_err_nxt = data_err;
    end else if (in_blk) begin
      len_nxt     = (len_r == c_len_sat) ? len_r : len_r + c_len_one;
      blk_err_nxt = blk_err_r | data_err;
    end
    close    = in_blk & rx_last_p1_i;
    size_err = close & ((len_nxt < c_len_min) | (len_nxt > c_len_max));
    block_ok = close & ~size_err & ~blk_err_nxt;
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state_r        <= st_idle;
      exp_r          <= '0;
      len_r          <= '0;
      blk_err_r      <= 1'b0;
      synced_o       <= 1'b0;
      rx_dreq_o      <= 1'b0;
      err_flags_p1_o <= '0;
    end else begin
      rx_dreq_o      <= enable_i;
      err_flags_p1_o <= {size_err, frame_err, data_err};
      if (rx_lost_p1_i) begin
        synced_o <= 1'b0;
        state_r  <= st_idle;
        len_r    <= '0;
      end else if (word) begin
        exp_r     <= rx_data_i + c_data_one;
        synced_o  <= 1'b1;
        len_r     <= len_nxt;
        blk_err_r <= blk_err_nxt;
        state_r   <= (in_blk && !rx_last_p1_i) ? st_in_block : st_idle;
      end
    end
  end

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i || clr_i) begin
      blocks_ok_o <= '0;
      err_data_o  <= '0;
      err_frame_o <= '0;
      err_size_o  <= '0;
      lost_o      <= '0;
    end else begin
      blocks_ok_o <= sat_inc(blocks_ok_o, block_ok);
      err_data_o  <= sat_inc(err_data_o, data_err);
      err_frame_o <= sat_inc(err_frame_o, frame_err);
      err_size_o  <= sat_inc(err_size_o, size_err);
      lost_o      <= sat_inc(lost_o, rx_lost_p1_i);
    end
  end

endmodule

// File: tb/tb_rx_block_checker.sv
// Directed testbench for rx_block_checker; a second instance with 4-bit counters
// shares the stimulus to exercise counter saturation.
module tb_rx_block_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clr;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        rx_first;
  logic        rx_last;
  logic        rx_lost;

  logic        dreq;
  logic        synced;
  logic [31:0] blocks_ok;
  logic [31:0] err_data;
  logic [31:0] err_frame;
  logic [31:0] err_size;
  logic [31:0] lost;
  logic [2:0]  flags;

  logic        s_dreq;
  logic        s_synced;
  logic [3:0]  s_blocks_ok;
  logic [3:0]  s_err_data;
  logic [3:0]  s_err_frame;
  logic [3:0]  s_err_size;
  logic [3:0]  s_lost;
  logic [2:0]  s_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_block_checker dut (
    .clk_sys_i      (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .clr_i          (clr),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .rx_first_p1_i  (rx_first),
    .rx_last_p1_i   (rx_last),
    .rx_lost_p1_i   (rx_lost),
    .rx_dreq_o      (dreq),
    .synced_o       (synced),
    .blocks_ok_o    (blocks_ok),
    .err_data_o     (err_data),
    .err_frame_o    (err_frame),
    .err_size_o     (err_size),
    .lost_o         (lost),
    .err_flags_p1_o (flags)
  );

  rx_block_checker #(.g_cnt_width(4)) dut_small (
    .clk_sys_i      (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .clr_i          (clr),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .rx_first_p1_i  (rx_first),
    .rx_last_p1_i   (rx_last),
    .rx_lost_p1_i   (rx_lost),
    .rx_dreq_o      (s_dreq),
    .synced_o       (s_synced),
    .blocks_ok_o    (s_blocks_ok),
    .err_data_o     (s_err_data),
    .err_frame_o    (s_err_frame),
    .err_size_o     (s_err_size),
    .lost_o         (s_lost),
    .err_flags_p1_o (s_flags)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic f, input logic l);
    rx_valid = 1'b1;
    rx_data  = d;
    rx_first = f;
    rx_last  = l;
    step();
    rx_valid = 1'b0;
    rx_first = 1'b0;
    rx_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; clr = 1'b0; rx_lost = 1'b0;
    rx_valid = 1'b0; rx_first = 1'b0; rx_last = 1'b0; rx_data = '0;
    step();
    step();
    checks++; if (dreq !== 1'b0) begin errors++; $display("[TB] FAIL reset_dreq got %b exp 0", dreq); end
    checks++; if (synced !== 1'b0) begin errors++; $display("[TB] FAIL reset_synced got %b exp 0", synced); end
    checks++; if (blocks_ok !== 0 || err_data !== 0 || err_frame !== 0 || err_size !== 0 || lost !== 0) begin
      errors++; $display("[TB] FAIL reset_counters got %0d %0d %0d %0d %0d exp all 0",
                         blocks_ok, err_data, err_frame, err_size, lost);
    end
    checks++; if (flags !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b exp 000", flags); end
    rst = 1'b0;
    step();
    checks++; if (dreq !== 1'b1) begin errors++; $display("[TB] FAIL dreq_enable got %b exp 1", dreq); end
  endtask

  task automatic test_good_blocks();
    logic [2:0] flag_or;
    flag_or = '0;
    send(64'd0, 1'b1, 1'b1); flag_or |= flags;
    send(64'd1, 1'b1, 1'b0); flag_or |= flags;
    send(64'd2, 1'b0, 1'b1); flag_or |= flags;
    send(64'd3, 1'b1, 1'b0); flag_or |= flags;
    send(64'd4, 1'b0, 1'b0); flag_or |= flags;
    send(64'd5, 1'b0, 1'b1); flag_or |= flags;
    checks++; if (synced !== 1'b1) begin errors++; $display("[TB] FAIL good_synced got %b exp 1", synced); end
    checks++; if (blocks_ok !== 32'd3) begin errors++; $display("[TB] FAIL good_blocks_ok got %0d exp 3", blocks_ok); end
    checks++; if (err_data !== 0 || err_frame !== 0 || err_size !== 0) begin
      errors++; $display("[TB] FAIL good_errs got %0d %0d %0d exp 0 0 0", err_data, err_frame, err_size);
    end
    checks++; if (flag_or !== 3'b000) begin errors++; $display("[TB] FAIL good_flags got %b exp 000", flag_or); end
  endtask

  task automatic test_data_gap();
    enable = 1'b0;
    send(64'd6, 1'b1, 1'b0);
    send(64'd7, 1'b0, 1'b0);
    checks++; if (flags !== 3'b000) begin errors++; $display("[TB] FAIL gap_flags_pre got %b exp 000", flags); end
    send(64'd9, 1'b0, 1'b1);
    checks++; if (flags !== 3'b001) begin errors++; $display("[TB] FAIL gap_flags got %b exp 001", flags); end
    checks++; if (err_data !== 32'd1) begin errors++; $display("[TB] FAIL gap_err_data got %0d exp 1", err_data); end
    checks++; if (blocks_ok !== 32'd3) begin errors++; $display("[TB] FAIL gap_blocks_ok got %0d exp 3", blocks_ok); end
    checks++; if (dreq !== 1'b0) begin errors++; $display("[TB] FAIL gap_dreq got %b exp 0", dreq); end
    step();
    checks++; if (flags !== 3'b000) begin errors++; $display("[TB] FAIL gap_flags_pulse got %b exp 000", flags); end
    send(64'd10, 1'b1, 1'b1);
    checks++; if (blocks_ok !== 32'd4) begin errors++; $display("[TB] FAIL gap_next_ok got %0d exp 4", blocks_ok); end
    enable = 1'b1;
  endtask

  task automatic test_size_frame();
    send(64'd11, 1'b1, 1'b0);
    send(64'd12, 1'b0, 1'b0);
    send(64'd13, 1'b0, 1'b0);
    send(64'd14, 1'b0, 1'b1);
    checks++; if (flags !== 3'b100) begin errors++; $display("[TB] FAIL size_flags got %b exp 100", flags); end
    checks++; if (err_size !== 32'd1) begin errors++; $display("[TB] FAIL size_err got %0d exp 1", err_size); end
    checks++; if (blocks_ok !== 32'd4) begin errors++; $display("[TB] FAIL size_blocks_ok got %0d exp 4", blocks_ok); end
    send(64'd15, 1'b0, 1'b0);
    checks++; if (flags !== 3'b010) begin errors++; $display("[TB] FAIL frame_flags got %b exp 010", flags); end
    checks++; if (err_frame !== 32'd1) begin errors++; $display("[TB] FAIL frame_err got %0d exp 1", err_frame); end
    send(64'd16, 1'b1, 1'b0);
    send(64'd17, 1'b0, 1'b1);
    checks++; if (blocks_ok !== 32'd5) begin errors++; $display("[TB] FAIL frame_next_ok got %0d exp 5", blocks_ok); end
    checks++; if (err_data !== 32'd1) begin errors++; $display("[TB] FAIL frame_err_data got %0d exp 1", err_data); end
  endtask

  task automatic test_lost();
    send(64'd18, 1'b1, 1'b0);
    send(64'd19, 1'b0, 1'b0);
    rx_lost = 1'b1;
    step();
    rx_lost = 1'b0;
    checks++; if (lost !== 32'd1) begin errors++; $display("[TB] FAIL lost_count got %0d exp 1", lost); end
    checks++; if (synced !== 1'b0) begin errors++; $display("[TB] FAIL lost_synced got %b exp 0", synced); end
    send(64'd100, 1'b1, 1'b0);
    checks++; if (synced !== 1'b1) begin errors++; $display("[TB] FAIL lost_resync got %b exp 1", synced); end
    send(64'd101, 1'b0, 1'b1);
    checks++; if (blocks_ok !== 32'd6) begin errors++; $display("[TB] FAIL lost_blocks_ok got %0d exp 6", blocks_ok); end
    checks++; if (err_data !== 32'd1 || err_frame !== 32'd1) begin
      errors++; $display("[TB] FAIL lost_errs got %0d %0d exp 1 1", err_data, err_frame);
    end
  endtask

  task automatic test_collision_saturation();
    rx_lost = 1'b1;
    send(64'd200, 1'b1, 1'b1);
    rx_lost = 1'b0;
    checks++; if (lost !== 32'd2) begin errors++; $display("[TB] FAIL coll_lost got %0d exp 2", lost); end
    checks++; if (blocks_ok !== 32'd6 || flags !== 3'b000 || synced !== 1'b0) begin
      errors++; $display("[TB] FAIL coll_ignored got ok=%0d flags=%b synced=%b exp 6 000 0", blocks_ok, flags, synced);
    end
    for (int i = 0; i < 16; i++) begin
      rx_lost = 1'b1;
      step();
    end
    rx_lost = 1'b0;
    checks++; if (s_lost !== 4'd15) begin errors++; $display("[TB] FAIL sat_small_lost got %0d exp 15", s_lost); end
    checks++; if (lost !== 32'd18) begin errors++; $display("[TB] FAIL sat_big_lost got %0d exp 18", lost); end
    checks++; if (s_blocks_ok !== 4'd6) begin errors++; $display("[TB] FAIL sat_small_ok got %0d exp 6", s_blocks_ok); end
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    send(64'd0, 1'b0, 1'b1);
    checks++; if (blocks_ok !== 32'd7 || err_data !== 32'd1) begin
      errors++; $display("[TB] FAIL wrap got ok=%0d err_data=%0d exp 7 1", blocks_ok, err_data);
    end
  endtask

  task automatic test_clear();
    send(64'd1, 1'b1, 1'b0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++; if (blocks_ok !== 0 || err_data !== 0 || err_frame !== 0 || err_size !== 0 || lost !== 0) begin
      errors++; $display("[TB] FAIL clr_counters got %0d %0d %0d %0d %0d exp all 0",
                         blocks_ok, err_data, err_frame, err_size, lost);
    end
    checks++; if (s_lost !== 4'd0) begin errors++; $display("[TB] FAIL clr_small_lost got %0d exp 0", s_lost); end
    checks++; if (synced !== 1'b1) begin errors++; $display("[TB] FAIL clr_synced got %b exp 1", synced); end
    send(64'd2, 1'b0, 1'b1);
    checks++; if (blocks_ok !== 32'd1 || err_frame !== 32'd0) begin
      errors++; $display("[TB] FAIL clr_complete got ok=%0d frame=%0d exp 1 0", blocks_ok, err_frame);
    end
    clr = 1'b1;
    send(64'd3, 1'b1, 1'b1);
    clr = 1'b0;
    checks++; if (blocks_ok !== 32'd0) begin errors++; $display("[TB] FAIL clr_vs_inc got %0d exp 0", blocks_ok); end
  endtask

  task automatic test_reset_mid_block();
    send(64'd4, 1'b1, 1'b0);
    send(64'd7, 1'b0, 1'b0);
    checks++; if (flags !== 3'b001 || err_data !== 32'd1) begin
      errors++; $display("[TB] FAIL mid_pre got flags=%b err_data=%0d exp 001 1", flags, err_data);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (flags !== 3'b000 || err_data !== 0 || synced !== 1'b0 || dreq !== 1'b0 || blocks_ok !== 0) begin
      errors++; $display("[TB] FAIL mid_reset got flags=%b err_data=%0d synced=%b dreq=%b ok=%0d exp all 0",
                         flags, err_data, synced, dreq, blocks_ok);
    end
    step();
    send(64'd8, 1'b0, 1'b1);
    checks++; if (err_frame !== 32'd1 || blocks_ok !== 0 || err_size !== 0 || err_data !== 0) begin
      errors++; $display("[TB] FAIL mid_dropped got frame=%0d ok=%0d size=%0d data=%0d exp 1 0 0 0",
                         err_frame, blocks_ok, err_size, err_data);
    end
  endtask

  initial begin
    test_reset();
    test_good_blocks();
    test_data_gap();
    test_size_frame();
    test_lost();
    test_collision_saturation();
    test_clear();
    test_reset_mid_block();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
